// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if: PC fetch handshake, instruction memory port and decode handshake bundled for instr_fetch_unit
interface instr_fetch_unit_if #(
  parameter int ADDR_W = 10
);
  logic [31:0]       fetch_addr;
  logic              fetch_req;
  logic              fetch_ack;
  logic              flush;
  logic              imem_en;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_rdata;
  logic [31:0]       instr;
  logic [31:0]       instr_pc;
  logic              instr_fault;
  logic              instr_valid;
  logic              instr_ready;
  modport slave (
    input  fetch_addr, fetch_req, flush, imem_rdata, instr_ready,
    output fetch_ack, imem_en, imem_addr, instr, instr_pc, instr_fault, instr_valid
  );
  modport master (
    output fetch_addr, fetch_req, flush, imem_rdata, instr_ready,
    input  fetch_ack, imem_en, imem_addr, instr, instr_pc, instr_fault, instr_valid
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: accepts PC addresses (sysclk/sysreset plain, bus = fetch/imem/decode signals), reads 1-cycle imem, buffers words in a flushable FIFO for decode
module instr_fetch_unit #(
  parameter int          ADDR_W     = 10,
  parameter int          FIFO_DEPTH = 2,
  parameter logic [31:0] NOP_WORD   = 32'h00000013
) (
  input logic               sysclk,
  input logic               sysreset,
  instr_fetch_unit_if.slave bus
);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  typedef struct packed {
    logic [31:0] w;
    logic [31:0] pc;
    logic        f;
  } entry_t;
  entry_t        fifo_q [FIFO_DEPTH];
  entry_t        head;
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic [CW:0]   occ;
  logic          inflight, inf_fault, pop, push;
  logic [31:0]   inf_pc;
  assign pop   = bus.instr_valid & bus.instr_ready;
  assign push  = inflight & ~bus.flush;
  assign occ   = {1'b0, count} + {{CW{1'b0}}, inflight} - {{CW{1'b0}}, pop};
  assign bus.fetch_ack = ~sysreset & bus.fetch_req & ~bus.flush & (occ < (CW+1)'(FIFO_DEPTH));
  assign bus.imem_en   = bus.fetch_ack;
  assign bus.imem_addr = sysreset ? '0 : bus.fetch_addr[ADDR_W-1:0];
  assign head            = fifo_q[rd_ptr];
  assign bus.instr_valid = count != '0;
  assign bus.instr       = bus.instr_valid ? head.w : '0;
  assign bus.instr_pc    = bus.instr_valid ? head.pc : '0;
  assign bus.instr_fault = bus.instr_valid & head.f;
  always_ff @(posedge sysclk)
    if (push) fifo_q[wr_ptr] <= '{w: inf_fault ? NOP_WORD : bus.imem_rdata, pc: inf_pc, f: inf_fault};
  always_ff @(posedge sysclk or posedge sysreset)
    if (sysreset) begin
      count     <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      inflight  <= 1'b0;
      inf_pc    <= '0;
      inf_fault <= 1'b0;
    end else begin
      inflight  <= bus.fetch_ack;
      inf_pc    <= bus.fetch_addr;
      inf_fault <= |bus.fetch_addr[31:ADDR_W];
      if (bus.flush) begin
        count  <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) wr_ptr <= (wr_ptr == PW'(FIFO_DEPTH-1)) ? '0 : wr_ptr + 1'b1;
        if (pop) rd_ptr <= (rd_ptr == PW'(FIFO_DEPTH-1)) ? '0 : rd_ptr + 1'b1;
        count <= count + CW'(push) - CW'(pop);
      end
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed stimulus with a scoreboard queue checked by a negedge monitor
module tb_instr_fetch_unit;
  logic sysclk = 1'b0;
  logic sysreset = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;
  typedef struct {
    logic [31:0] w;
    logic [31:0] pc;
    logic        f;
  } exp_t;
  exp_t exp_q[$];
  exp_t e_m;
  instr_fetch_unit_if #(.ADDR_W(10)) bus();
  instr_fetch_unit #(.ADDR_W(10), .FIFO_DEPTH(2), .NOP_WORD(32'h00000013)) dut (
    .sysclk(sysclk), .sysreset(sysreset), .bus(bus)
  );
  always #5 sysclk = ~sysclk;
  always @(posedge sysclk) if (bus.imem_en) bus.imem_rdata <= 32'hC0DE0000 | {22'b0, bus.imem_addr};
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic exp_t model(input logic [31:0] a);
    exp_t r;
    r.f  = |a[31:10];
    r.w  = r.f ? 32'h00000013 : (32'hC0DE0000 | {22'b0, a[9:0]});
    r.pc = a;
    return r;
  endfunction
  always @(negedge sysclk) begin
    if (sysreset) exp_q.delete();
    else begin
      if (bus.instr_valid && bus.instr_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL sb_unexpected: got pc %h expected no delivery", bus.instr_pc);
        end else begin
          e_m = exp_q.pop_front();
          chk("sb_instr", bus.instr, e_m.w);
          chk("sb_pc", bus.instr_pc, e_m.pc);
          chk("sb_fault", {31'b0, bus.instr_fault}, {31'b0, e_m.f});
        end
      end
      if (bus.flush) exp_q.delete();
      else if (bus.fetch_ack) exp_q.push_back(model(bus.fetch_addr));
    end
  end
  task automatic cyc();
    @(posedge sysclk);
    #1;
  endtask
  task automatic fetch_seq(input logic [31:0] a0, input int n);
    int got = 0;
    int budget = 0;
    bus.fetch_addr = a0;
    bus.fetch_req  = 1'b1;
    while (got < n && budget < 50) begin
      @(negedge sysclk);
      if (bus.fetch_ack) got++;
      cyc();
      bus.fetch_addr = a0 + got;
      budget++;
    end
    bus.fetch_req = 1'b0;
    chk("fetch_budget", got, n);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end
  initial begin
    int acks, occ_tb;
    logic [31:0] a;
    bus.fetch_addr = 32'h7; bus.fetch_req = 1'b1; bus.flush = 1'b0;
    bus.instr_ready = 1'b0; bus.imem_rdata = '0;
    @(negedge sysclk);
    chk("rst_valid", {31'b0, bus.instr_valid}, 0);
    chk("rst_instr", bus.instr, 0);
    chk("rst_pc", bus.instr_pc, 0);
    chk("rst_ack", {31'b0, bus.fetch_ack}, 0);
    chk("rst_imem_en", {31'b0, bus.imem_en}, 0);
    chk("rst_imem_addr", {22'b0, bus.imem_addr}, 0);
    cyc();
    bus.fetch_req = 1'b0;
    sysreset = 1'b0;
    cyc();
    bus.fetch_req = 1'b1; bus.fetch_addr = 32'd5;
    @(negedge sysclk);
    chk("lat_ack", {31'b0, bus.fetch_ack}, 1);
    chk("lat_imem_addr", {22'b0, bus.imem_addr}, 5);
    cyc();
    bus.fetch_req = 1'b0;
    @(negedge sysclk);
    chk("lat_n1_valid", {31'b0, bus.instr_valid}, 0);
    cyc();
    @(negedge sysclk);
    chk("lat_n2_valid", {31'b0, bus.instr_valid}, 1);
    chk("lat_n2_instr", bus.instr, 32'hC0DE0005);
    chk("lat_n2_pc", bus.instr_pc, 5);
    cyc();
    bus.instr_ready = 1'b1;
    cyc();
    for (int i = 0; i < 10; i++) begin
      bus.fetch_addr = i; bus.fetch_req = 1'b1;
      @(negedge sysclk);
      chk("stream_ack", {31'b0, bus.fetch_ack}, 1);
      if (i >= 2) begin
        chk("stream_valid", {31'b0, bus.instr_valid}, 1);
        chk("stream_pc", bus.instr_pc, i - 2);
      end
      cyc();
    end
    bus.fetch_req = 1'b0;
    repeat (4) cyc();
    chk("stream_drained", exp_q.size(), 0);
    bus.instr_ready = 1'b0;
    acks = 0;
    bus.fetch_addr = 0; bus.fetch_req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge sysclk);
      if (bus.fetch_ack) acks++;
      cyc();
      bus.fetch_addr = acks;
    end
    chk("bp_acks", acks, 2);
    @(negedge sysclk);
    chk("bp_ack_held", {31'b0, bus.fetch_ack}, 0);
    chk("bp_head_pc", bus.instr_pc, 0);
    chk("bp_head_instr", bus.instr, 32'hC0DE0000);
    cyc();
    bus.instr_ready = 1'b1;
    @(negedge sysclk);
    chk("bp_resume_ack", {31'b0, bus.fetch_ack}, 1);
    cyc();
    bus.fetch_req = 1'b0;
    repeat (4) cyc();
    chk("bp_drained", exp_q.size(), 0);
    bus.instr_ready = 1'b0;
    fetch_seq(32'd10, 1);
    bus.fetch_req = 1'b1; bus.fetch_addr = 32'd8;
    @(negedge sysclk);
    chk("flush_ack8", {31'b0, bus.fetch_ack}, 1);
    cyc();
    bus.flush = 1'b1; bus.fetch_addr = 32'd20;
    @(negedge sysclk);
    chk("flush_no_ack", {31'b0, bus.fetch_ack}, 0);
    chk("flush_buffered", {31'b0, bus.instr_valid}, 1);
    cyc();
    bus.flush = 1'b0;
    @(negedge sysclk);
    chk("flush_cleared", {31'b0, bus.instr_valid}, 0);
    chk("flush_ack20", {31'b0, bus.fetch_ack}, 1);
    cyc();
    bus.fetch_req = 1'b0;
    @(negedge sysclk);
    chk("flush_drop8", {31'b0, bus.instr_valid}, 0);
    cyc();
    @(negedge sysclk);
    chk("flush_valid20", {31'b0, bus.instr_valid}, 1);
    chk("flush_pc20", bus.instr_pc, 20);
    chk("flush_instr20", bus.instr, 32'hC0DE0014);
    cyc();
    bus.instr_ready = 1'b1;
    cyc();
    bus.instr_ready = 1'b0;
    fetch_seq(32'h400, 1);
    @(negedge sysclk);
    chk("fault_n1_valid", {31'b0, bus.instr_valid}, 0);
    cyc();
    @(negedge sysclk);
    chk("fault_instr", bus.instr, 32'h00000013);
    chk("fault_flag", {31'b0, bus.instr_fault}, 1);
    chk("fault_pc", bus.instr_pc, 32'h400);
    cyc();
    bus.instr_ready = 1'b1;
    cyc();
    bus.instr_ready = 1'b0;
    fetch_seq(32'd32, 2);
    cyc();
    occ_tb = 2;
    a = 32'd34;
    for (int i = 0; i < 10; i++) begin
      bus.instr_ready = (i % 2 == 0);
      bus.fetch_req = 1'b1; bus.fetch_addr = a;
      @(negedge sysclk);
      occ_tb = occ_tb + int'(bus.fetch_ack) - int'(bus.instr_valid & bus.instr_ready);
      chk("pp_occ_le_depth", {31'b0, occ_tb <= 2}, 1);
      if (bus.fetch_ack) a++;
      cyc();
    end
    bus.fetch_req = 1'b0; bus.instr_ready = 1'b1;
    repeat (4) cyc();
    chk("pp_drained", exp_q.size(), 0);
    bus.instr_ready = 1'b0;
    fetch_seq(32'd40, 2);
    cyc();
    bus.fetch_req = 1'b1; bus.fetch_addr = 32'h55;
    @(negedge sysclk);
    chk("mid_full_valid", {31'b0, bus.instr_valid}, 1);
    chk("mid_full_ack", {31'b0, bus.fetch_ack}, 0);
    cyc();
    #2 sysreset = 1'b1;
    #1;
    chk("mid_rst_valid", {31'b0, bus.instr_valid}, 0);
    chk("mid_rst_instr", bus.instr, 0);
    chk("mid_rst_pc", bus.instr_pc, 0);
    chk("mid_rst_fault", {31'b0, bus.instr_fault}, 0);
    chk("mid_rst_ack", {31'b0, bus.fetch_ack}, 0);
    chk("mid_rst_imem_en", {31'b0, bus.imem_en}, 0);
    chk("mid_rst_imem_addr", {22'b0, bus.imem_addr}, 0);
    cyc();
    cyc();
    sysreset = 1'b0; bus.fetch_req = 1'b0;
    cyc();
    fetch_seq(32'd5, 1);
    @(negedge sysclk);
    chk("post_rst_n1_valid", {31'b0, bus.instr_valid}, 0);
    cyc();
    @(negedge sysclk);
    chk("post_rst_valid", {31'b0, bus.instr_valid}, 1);
    chk("post_rst_pc", bus.instr_pc, 5);
    chk("post_rst_instr", bus.instr, 32'hC0DE0005);
    cyc();
    bus.instr_ready = 1'b1;
    repeat (3) cyc();
    chk("final_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
